// File: rtl/update_knn8_div_seq.sv
// Radix-2 restoring unsigned divider with valid/ready handshakes and a global clock enable.
// Recovers quotient/remainder from update_knn8 products; one quotient bit per enabled BUSY cycle.
module update_knn8_div_seq #(
    parameter int unsigned DIVIDEND_WIDTH = 32,
    parameter int unsigned DIVISOR_WIDTH  = 15,
    parameter int unsigned CNT_WIDTH      = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DIVIDEND_WIDTH);

    state_t                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_WIDTH-1:0] shift_q, shift_d;
    logic [DIVISOR_WIDTH-1:0]  dsr_q, dsr_d;
    logic [DIVISOR_WIDTH:0]    prem_q, prem_d;
    logic [DIVIDEND_WIDTH-1:0] quot_q, quot_d;
    logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
    logic                      dbz_q, dbz_d;

    logic [DIVISOR_WIDTH+1:0]  prem_sh;
    logic [DIVISOR_WIDTH:0]    prem_sub;
    logic                      q_bit;
    logic                      accept;
    logic                      out_hs;

    assign in_ready    = reset & ce & (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

    assign accept = in_valid & in_ready;
    assign out_hs = out_valid & out_ready & ce;

    // Partial remainder stays below the divisor, so the shifted value fits in one extra bit.
    always_comb begin
        prem_sh  = {prem_q, shift_q[DIVIDEND_WIDTH-1]};
        q_bit    = (prem_sh >= {2'b00, dsr_q});
        prem_sub = prem_sh[DIVISOR_WIDTH:0] - {1'b0, dsr_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_d = dividend;
                        dsr_d   = divisor;
                        prem_d  = '0;
                        cnt_d   = '0;
                        if (divisor == '0) begin
                            quot_d  = '1;
                            rem_d   = '0;
                            dbz_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    // One extra enabled cycle after the last iteration registers the result.
                    if (cnt_q == LAST_CNT) begin
                        quot_d  = shift_q;
                        rem_d   = prem_q[DIVISOR_WIDTH-1:0];
                        dbz_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        shift_d = {shift_q[DIVIDEND_WIDTH-2:0], q_bit};
                        prem_d  = q_bit ? prem_sub : prem_sh[DIVISOR_WIDTH:0];
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_hs) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: tb/tb_update_knn8_div_seq.sv
// Scoreboard bench for update_knn8_div_seq: stimulus queues expected results, a monitor
// compares them at each output handshake; latency, backpressure, ce stall and reset abort are checked inline.
module tb_update_knn8_div_seq;

    typedef struct {
        logic [31:0] q;
        logic [14:0] r;
        logic        z;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [14:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [14:0] remainder;
    logic        div_by_zero;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    bit   rand_mode = 0;

    update_knn8_div_seq #(
        .DIVIDEND_WIDTH(32),
        .DIVISOR_WIDTH (15),
        .CNT_WIDTH     (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: pop and compare on every output handshake; also verify hold stability under backpressure.
    initial begin : monitor
        logic        prev_hold;
        logic [31:0] snap_q;
        logic [14:0] snap_r;
        logic        snap_z;
        exp_t        e;
        prev_hold = 1'b0;
        snap_q = '0;
        snap_r = '0;
        snap_z = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_quotient", quotient, snap_q);
                    check("hold_remainder", 32'(remainder), 32'(snap_r));
                    check("hold_dbz", 32'(div_by_zero), 32'(snap_z));
                end
                if (out_valid && out_ready && ce) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("quotient", quotient, e.q);
                        check("remainder", 32'(remainder), 32'(e.r));
                        check("div_by_zero", 32'(div_by_zero), 32'(e.z));
                    end
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = out_valid;
                end
                snap_q = quotient;
                snap_r = remainder;
                snap_z = div_by_zero;
            end
        end
    end

    // Random ce/out_ready stalls for the regression phase.
    always @(negedge clk) begin
        if (rand_mode) begin
            ce        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic send(input logic [31:0] a, input logic [14:0] b,
                        input logic [31:0] q, input logic [14:0] r, input logic z);
        exp_t e;
        int   guard;
        e.q = q;
        e.r = r;
        e.z = z;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        guard    = 0;
        #1;
        while (!in_ready && guard < 3000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 15'($urandom);
    endtask

    // Called at the negedge after the accept edge; counts posedges until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        #1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            #1;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin : stim
        int          lat;
        int          guard;
        logic [31:0] a;
        logic [14:0] b;
        logic [31:0] fq;
        logic [14:0] fr;
        reset     = 1'b0;
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1000/7 with exact latency and single-cycle valid
        send(32'd1000, 15'd7, 32'd142, 15'd6, 1'b0);
        wait_out(lat);
        check("latency_1000_7", 32'(lat), 32'd33);
        @(negedge clk);
        #1;
        check("valid_one_cycle", 32'(out_valid), 32'd0);

        send(32'hFFFF_FFFF, 15'h7FFF, 32'h0002_0004, 15'd3, 1'b0);
        send(32'd5, 15'd9, 32'd0, 15'd5, 1'b0);
        send(32'h1234_5678, 15'd1, 32'h1234_5678, 15'd0, 1'b0);

        // divide by zero then a normal op
        send(32'd123, 15'd0, 32'hFFFF_FFFF, 15'd0, 1'b1);
        wait_out(lat);
        check("latency_dbz", 32'(lat), 32'd0);
        send(32'd10, 15'd3, 32'd3, 15'd1, 1'b0);
        wait_out(lat);
        check("latency_10_3", 32'(lat), 32'd33);

        // backpressure
        @(negedge clk);
        out_ready = 1'b0;
        send(32'd200, 15'd9, 32'd22, 15'd2, 1'b0);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);

        // ce dropped for 10 cycles starting at BUSY iteration 12 of 100/10
        send(32'd100, 15'd10, 32'd10, 15'd0, 1'b0);
        fork
            wait_out(lat);
            begin
                repeat (11) @(negedge clk);
                ce = 1'b0;
                fq = quotient;
                fr = remainder;
                for (int i = 0; i < 10; i++) begin
                    #1;
                    check("ce_in_ready", 32'(in_ready), 32'd0);
                    check("ce_out_valid", 32'(out_valid), 32'd0);
                    check("ce_quotient", quotient, fq);
                    check("ce_remainder", 32'(remainder), 32'(fr));
                    @(negedge clk);
                end
                ce = 1'b1;
            end
        join
        check("latency_ce_stall", 32'(lat), 32'd43);

        // reset mid-BUSY aborts the op
        send(32'd500, 15'd3, 32'd166, 15'd2, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        guard = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) guard++;
        end
        check("abort_no_valid", 32'(guard), 32'd0);
        send(32'd77, 15'd8, 32'd9, 15'd5, 1'b0);
        wait_out(lat);

        // random regression with stalls
        rand_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            case (i % 5)
                0: b = 15'd1;
                1: b = 15'h7FFF;
                2: begin
                    b = 15'($urandom_range(2, 32767));
                    a = 32'($urandom_range(0, 32'(b) - 1));
                end
                3: b = (i % 15 == 3) ? 15'd0 : 15'($urandom_range(1, 32767));
                default: b = 15'($urandom_range(1, 32767));
            endcase
            if (b == 15'd0) send(a, b, 32'hFFFF_FFFF, 15'd0, 1'b1);
            else send(a, b, a / 32'(b), 15'(a % 32'(b)), 1'b0);
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        rand_mode = 1'b0;
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
